// File: rtl/cpu_types.sv
// Shared CPU type definitions: reservation-station tags, CDB bundle,
// functional-unit port indices and arbiter sizing.
package cpu_types;

    localparam int NUM_FU_DEFAULT = 4;
    localparam int NUM_FU_MAX     = 8;

    typedef enum logic [3:0] {
        INVALID = 4'd0,
        ALU     = 4'd1,
        MULT    = 4'd2,
        LOAD    = 4'd3,
        STORE   = 4'd4,
        BRANCH  = 4'd5
    } RS_tag_type;

    typedef struct packed {
        RS_tag_type  tag;
        logic [31:0] data;
    } cdb_t;

    typedef enum logic [2:0] {
        FU_ALU0 = 3'd0,
        FU_ALU1 = 3'd1,
        FU_MUL  = 3'd2,
        FU_LSU  = 3'd3,
        FU_BR   = 3'd4,
        FU_FP   = 3'd5,
        FU_DIV  = 3'd6,
        FU_CSR  = 3'd7
    } fu_port_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit result handshake and CDB broadcast bundle.
// master = FU side, slave = arbiter side.
interface cdb_arbiter_if
    import cpu_types::*;
#(
    parameter int NUM_FU = NUM_FU_DEFAULT
);
    logic       [NUM_FU-1:0]       FU_VALID;
    RS_tag_type [NUM_FU-1:0]       FU_TAG;
    logic       [NUM_FU-1:0][31:0] FU_DATA;
    logic       [NUM_FU-1:0]       FU_READY;
    cdb_t                          cdb_out;
    logic       [NUM_FU-1:0]       GRANT;

    modport master (
        output FU_VALID,
        output FU_TAG,
        output FU_DATA,
        input  FU_READY,
        input  cdb_out,
        input  GRANT
    );

    modport slave (
        input  FU_VALID,
        input  FU_TAG,
        input  FU_DATA,
        output FU_READY,
        output cdb_out,
        output GRANT
    );
endinterface

// File: rtl/cdb_rr_pick.sv
// Rotating-priority picker: first set bit of full at or after ptr,
// wrapping modulo NUM_FU.
module cdb_rr_pick #(
    parameter int NUM_FU = 4,
    parameter int PW     = 2
) (
    input  logic [NUM_FU-1:0] full,
    input  logic [PW-1:0]     ptr,
    output logic [PW-1:0]     winner,
    output logic              found
);
    int idx;

    // Scan farthest-first so the candidate closest to ptr is written last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_FU) begin
                idx = idx - NUM_FU;
            end
            if (full[idx]) begin
                winner = PW'(idx);
                found  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding entry per FU port, round-robin
// selection, one registered broadcast per cycle.
module cdb_arbiter
    import cpu_types::*;
#(
    parameter int NUM_FU = NUM_FU_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          FLUSH,
    cdb_arbiter_if.slave  bus
);
    localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic       [NUM_FU-1:0]       full;
    RS_tag_type [NUM_FU-1:0]       tag_q;
    logic       [NUM_FU-1:0][31:0] data_q;
    logic       [PW-1:0]           ptr;
    cdb_t                          cdb_q;
    logic       [NUM_FU-1:0]       grant_q;

    logic       [NUM_FU-1:0]       win;
    logic       [NUM_FU-1:0]       ready;
    logic       [NUM_FU-1:0]       xfer;
    logic       [PW-1:0]           winner;
    logic       [PW-1:0]           ptr_nxt;
    logic                          found;

    cdb_rr_pick #(
        .NUM_FU (NUM_FU),
        .PW     (PW)
    ) u_pick (
        .full   (full),
        .ptr    (ptr),
        .winner (winner),
        .found  (found)
    );

    always_comb begin
        win = '0;
        if (found) begin
            win[winner] = 1'b1;
        end
    end

    // A winning entry frees its slot this edge, so it may reload at once.
    assign ready   = (RST_N && !FLUSH) ? (~full | win) : '0;
    assign xfer    = bus.FU_VALID & ready;
    assign ptr_nxt = (winner == PW'(NUM_FU - 1)) ? '0 : winner + 1'b1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            full       <= '0;
            ptr        <= '0;
            cdb_q.tag  <= INVALID;
            cdb_q.data <= '0;
            grant_q    <= '0;
        end else if (FLUSH) begin
            full       <= '0;
            cdb_q.tag  <= INVALID;
            cdb_q.data <= '0;
            grant_q    <= '0;
        end else begin
            full    <= (full & ~win) | xfer;
            grant_q <= win;
            if (found) begin
                cdb_q.tag  <= tag_q[winner];
                cdb_q.data <= data_q[winner];
                ptr        <= ptr_nxt;
            end else begin
                cdb_q.tag  <= INVALID;
                cdb_q.data <= '0;
            end
        end
    end

    // Payload needs no reset: it is only observed through a set full flag.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (xfer[i]) begin
                tag_q[i]  <= bus.FU_TAG[i];
                data_q[i] <= bus.FU_DATA[i];
            end
        end
    end

    assign bus.FU_READY = ready;
    assign bus.cdb_out  = cdb_q;
    assign bus.GRANT    = grant_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: NUM_FU=4 and NUM_FU=3 instances,
// directed stimulus with hand-ordered expected broadcasts.
module tb_cdb_arbiter;
    import cpu_types::*;

    typedef struct packed {
        logic [3:0]  grant;
        RS_tag_type  tag;
        logic [31:0] data;
    } exp_t;

    logic CLK = 1'b0;
    logic RST_N;
    logic FLUSH;

    int errors = 0;
    int checks = 0;

    exp_t q4[$];
    exp_t q3[$];

    always #5 CLK = ~CLK;

    cdb_arbiter_if #(.NUM_FU(4)) b4 ();
    cdb_arbiter_if #(.NUM_FU(3)) b3 ();

    cdb_arbiter #(.NUM_FU(4)) dut4 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .FLUSH (FLUSH),
        .bus   (b4)
    );

    cdb_arbiter #(.NUM_FU(3)) dut3 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .FLUSH (FLUSH),
        .bus   (b3)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic push4(input logic [3:0] g, input RS_tag_type t,
                         input logic [31:0] d);
        exp_t e;
        e.grant = g;
        e.tag   = t;
        e.data  = d;
        q4.push_back(e);
    endtask

    task automatic push3(input logic [3:0] g, input RS_tag_type t,
                         input logic [31:0] d);
        exp_t e;
        e.grant = g;
        e.tag   = t;
        e.data  = d;
        q3.push_back(e);
    endtask

    always @(negedge CLK) begin : mon4
        exp_t e;
        if (b4.GRANT != '0) begin
            if (q4.size() == 0) begin
                chk("cdb4_unexpected", 64'(b4.GRANT), 64'd0);
            end else begin
                e = q4.pop_front();
                chk("cdb4_grant", 64'(b4.GRANT), 64'(e.grant));
                chk("cdb4_tag", 64'(b4.cdb_out.tag), 64'(e.tag));
                chk("cdb4_data", 64'(b4.cdb_out.data), 64'(e.data));
            end
        end else begin
            chk("cdb4_idle_tag", 64'(b4.cdb_out.tag), 64'(INVALID));
            chk("cdb4_idle_data", 64'(b4.cdb_out.data), 64'd0);
        end
    end

    always @(negedge CLK) begin : mon3
        exp_t e;
        if (b3.GRANT != '0) begin
            if (q3.size() == 0) begin
                chk("cdb3_unexpected", 64'(b3.GRANT), 64'd0);
            end else begin
                e = q3.pop_front();
                chk("cdb3_grant", 64'(b3.GRANT), 64'(e.grant));
                chk("cdb3_tag", 64'(b3.cdb_out.tag), 64'(e.tag));
                chk("cdb3_data", 64'(b3.cdb_out.data), 64'(e.data));
            end
        end else begin
            chk("cdb3_idle_tag", 64'(b3.cdb_out.tag), 64'(INVALID));
            chk("cdb3_idle_data", 64'(b3.cdb_out.data), 64'd0);
        end
    end

    initial begin : watchdog
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic       rdy_exp[5];
        logic       r;
        int         k;

        RST_N = 1'b0;
        FLUSH = 1'b0;
        b4.FU_VALID = '0;
        b4.FU_DATA  = '0;
        b3.FU_VALID = '0;
        b3.FU_DATA  = '0;
        for (int i = 0; i < 4; i++) b4.FU_TAG[i] = INVALID;
        for (int i = 0; i < 3; i++) b3.FU_TAG[i] = INVALID;

        // reset state
        repeat (2) tick();
        chk("rst_ready", 64'(b4.FU_READY), 64'd0);
        chk("rst_grant", 64'(b4.GRANT), 64'd0);
        chk("rst_tag", 64'(b4.cdb_out.tag), 64'(INVALID));
        RST_N = 1'b1;
        tick();
        chk("idle_ready", 64'(b4.FU_READY), 64'hF);

        // all four ports full at PTR=0; port 1 carries an INVALID tag
        b4.FU_VALID = 4'b1111;
        b4.FU_TAG[0] = ALU;     b4.FU_DATA[0] = 32'h0000_00A0;
        b4.FU_TAG[1] = INVALID; b4.FU_DATA[1] = 32'h0000_0011;
        b4.FU_TAG[2] = MULT;    b4.FU_DATA[2] = 32'h0000_0022;
        b4.FU_TAG[3] = LOAD;    b4.FU_DATA[3] = 32'h0000_0033;
        push4(4'b0001, ALU,     32'h0000_00A0);
        push4(4'b0010, INVALID, 32'h0000_0011);
        push4(4'b0100, MULT,    32'h0000_0022);
        push4(4'b1000, LOAD,    32'h0000_0033);
        tick();
        b4.FU_VALID = '0;
        repeat (6) tick();

        // single request on port 2, PTR=0
        b4.FU_VALID = 4'b0100;
        b4.FU_TAG[2] = ALU; b4.FU_DATA[2] = 32'h0000_00AA;
        push4(4'b0100, ALU, 32'h0000_00AA);
        tick();
        b4.FU_VALID = '0;
        repeat (3) tick();

        // flush with ports 1 and 3 full; PTR=3 is kept
        b4.FU_VALID = 4'b1010;
        b4.FU_TAG[1] = MULT; b4.FU_DATA[1] = 32'h0000_00B1;
        b4.FU_TAG[3] = LOAD; b4.FU_DATA[3] = 32'h0000_00B3;
        tick();
        b4.FU_VALID = '0;
        FLUSH = 1'b1;
        #2;
        chk("flush_ready", 64'(b4.FU_READY), 64'd0);
        tick();
        FLUSH = 1'b0;
        repeat (3) tick();
        b4.FU_VALID = 4'b1000;
        b4.FU_TAG[3] = STORE; b4.FU_DATA[3] = 32'h0000_00C3;
        push4(4'b1000, STORE, 32'h0000_00C3);
        tick();
        b4.FU_VALID = '0;
        repeat (2) tick();

        // port 0 streams while port 3 holds one entry, PTR=0
        push4(4'b0001, ALU,    32'h0000_00D0);
        push4(4'b1000, BRANCH, 32'h0000_00E3);
        push4(4'b0001, ALU,    32'h0000_00D1);
        push4(4'b0001, ALU,    32'h0000_00D2);
        push4(4'b0001, ALU,    32'h0000_00D3);
        rdy_exp[0] = 1'b1;
        rdy_exp[1] = 1'b1;
        rdy_exp[2] = 1'b0;
        rdy_exp[3] = 1'b1;
        rdy_exp[4] = 1'b1;
        k = 0;
        b4.FU_TAG[3] = BRANCH; b4.FU_DATA[3] = 32'h0000_00E3;
        b4.FU_VALID = 4'b1001;
        for (int c = 0; c < 5; c++) begin
            b4.FU_TAG[0]  = ALU;
            b4.FU_DATA[0] = 32'h0000_00D0 + 32'(k);
            @(negedge CLK);
            chk("stream_ready0", 64'(b4.FU_READY[0]), 64'(rdy_exp[c]));
            r = b4.FU_READY[0];
            tick();
            if (c == 0) b4.FU_VALID[3] = 1'b0;
            if (r) k++;
        end
        b4.FU_VALID = '0;
        chk("stream_accepted", 64'(k), 64'd4);
        repeat (3) tick();

        // reset mid-operation with port 2 still held
        b4.FU_VALID = 4'b0110;
        b4.FU_TAG[1] = MULT; b4.FU_DATA[1] = 32'h0000_00F1;
        b4.FU_TAG[2] = LOAD; b4.FU_DATA[2] = 32'h0000_00F2;
        push4(4'b0010, MULT, 32'h0000_00F1);
        tick();
        b4.FU_VALID = '0;
        @(posedge CLK);
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("midrst_tag", 64'(b4.cdb_out.tag), 64'(INVALID));
        chk("midrst_data", 64'(b4.cdb_out.data), 64'd0);
        chk("midrst_grant", 64'(b4.GRANT), 64'd0);
        chk("midrst_ready", 64'(b4.FU_READY), 64'd0);
        repeat (2) tick();
        RST_N = 1'b1;
        repeat (4) tick();

        // NUM_FU=3 build, all ports continuously full
        b3.FU_TAG[0] = ALU;  b3.FU_DATA[0] = 32'h0000_0300;
        b3.FU_TAG[1] = MULT; b3.FU_DATA[1] = 32'h0000_0301;
        b3.FU_TAG[2] = LOAD; b3.FU_DATA[2] = 32'h0000_0302;
        for (int n = 0; n < 11; n++) begin
            case (n % 3)
                0: push3(4'b0001, ALU,  32'h0000_0300);
                1: push3(4'b0010, MULT, 32'h0000_0301);
                default: push3(4'b0100, LOAD, 32'h0000_0302);
            endcase
        end
        b3.FU_VALID = 3'b111;
        repeat (9) tick();
        b3.FU_VALID = '0;
        repeat (6) tick();

        chk("q4_drained", 64'(q4.size()), 64'd0);
        chk("q3_drained", 64'(q3.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 4: number of functional-unit requester ports; legal range 1..8.
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 RST_N  input  1  reset, asynchronous and active-low.
REQ-004 FLUSH  input  1  synchronous clear of all holding entries; the round-robin pointer is kept.
REQ-005 FU_VALID  input  NUM_FU  per-FU result-valid flag.
REQ-006 FU_TAG  input  NUM_FU x RS_tag_type  per-FU producing reservation-station tag.
REQ-007 FU_DATA  input  NUM_FU x 32  per-FU result value.
REQ-008 FU_READY  output  NUM_FU  per-FU acceptance; a transfer occurs when FU_VALID[i] and FU_READY[i] are both high at a rising edge.
REQ-009 cdb_out  output  cdb_t  registered tag/data broadcast to all reservation stations and the map table.
REQ-010 GRANT  output  NUM_FU  registered one-hot; bit i set when cdb_out carries port i's entry.

Function
REQ-011 Each port SHALL own a one-entry holding register: full flag, tag, data.
REQ-012 FU_READY[i] SHALL be high when entry i is empty, or when it is full and wins arbitration this cycle, provided FLUSH is low.
REQ-013 FU_READY SHALL be low for all ports while FLUSH is high.
REQ-014 Arbitration SHALL be combinational over the full entries: the first full entry at or after pointer PTR, wrapping modulo NUM_FU, wins.
REQ-015 At the edge after a win:
- cdb_out gets the winner's tag and data.
- GRANT gets the winner's one-hot bit.
- The winner's entry clears, unless it is reloaded in the same edge.
- PTR becomes (winner+1) mod NUM_FU.
REQ-016 With no full entry and no FLUSH, the next cdb_out SHALL be tag INVALID, data 0, and GRANT 0; PTR is unchanged.
REQ-017 Exactly one broadcast SHALL occur per cycle at most, and no accepted entry may be lost or duplicated.
REQ-018 Latency: an entry accepted at edge E SHALL appear on cdb_out no earlier than after edge E+1; there is no input-to-CDB bypass.
REQ-019 Starvation bound: a full entry SHALL be broadcast within NUM_FU cycles.
REQ-020 Simultaneous win and new transfer on the same port: the old entry broadcasts and the new entry loads; the full flag stays set.
REQ-021 FLUSH high at an edge:
- All full flags clear.
- cdb_out becomes INVALID/0 and GRANT becomes 0.
- FLUSH overrides any same-cycle win or transfer.
REQ-022 A port with FU_TAG equal to INVALID SHALL still be accepted and broadcast unchanged; the arbiter does not check tags.
REQ-023 PTR SHALL be $clog2(NUM_FU) bits wide, minimum 1, and its wrap SHALL be explicit (NUM_FU-1 -> 0) for non-power-of-two NUM_FU.
REQ-024 With NUM_FU=1, PTR SHALL stay 0 and the port SHALL broadcast every cycle it holds an entry.

Reset
REQ-025 While RST_N is low, the following SHALL hold immediately, independent of CLK:
- All full flags 0.
- PTR 0.
- cdb_out tag INVALID, data 0.
- GRANT 0.
REQ-026 FU_READY SHALL be low while RST_N is low and SHALL follow REQ-012 from the first edge after release.
REQ-027 Reset asserted mid-operation SHALL discard all held entries with no partial broadcast.

Structure
REQ-028 cdb_t, RS_tag_type and INVALID SHALL come from cpu_types; the FU port index enumeration and NUM_FU default SHALL be added to cpu_types.
REQ-029 Rotating-priority selection SHALL be a separate combinational sub-module, cdb_rr_pick, with inputs full vector and PTR and outputs winner index and found flag.
REQ-030 All registers SHALL reside in cdb_arbiter.

Verification
REQ-031 Single request: port 2 sends tag ALU, data 0x0000_00AA at edge 1 -> after edge 2, cdb_out = {ALU, 0xAA} and GRANT = 0100; after edge 3, cdb_out tag = INVALID.
REQ-032 All four ports full, PTR=0, no new input -> GRANT sequence over four cycles is 0001, 0010, 0100, 1000, then 0; each tag appears exactly once.
REQ-033 Port 0 streams continuously with FU_VALID held high while port 3 holds one entry -> port 3 broadcasts within 4 cycles; port 0's FU_READY stays high on every cycle it wins.
REQ-034 FLUSH with ports 1 and 3 full -> next cdb_out is INVALID/0 with GRANT 0; neither entry ever broadcasts; a later request broadcasts normally.
REQ-035 RST_N dropped mid-cycle while cdb_out shows a valid tag -> cdb_out becomes INVALID before the next CLK edge; after release, with no requests, it stays INVALID.
REQ-036 NUM_FU=3 build: all ports continuously full -> PTR wraps 2 -> 0 and GRANT cycles 001, 010, 100 repeatedly.
